// File: rtl/reg2_write_arbiter_pkg.sv
// Shared definitions for the reg2 write arbiter: FSM state encoding and parameter limits.
package reg2_write_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_WRITE = 2'b01;
  localparam state_t ST_ACK   = 2'b10;

  localparam int REG2ARB_MAX_REQ = 8;

endpackage

// File: rtl/reg2_write_arbiter_if.sv
// Requester-side bundle of the shared register: requests and data in, grant/ack/value/busy out.
interface reg2_write_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int DW    = 2
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       q;
  logic                busy;

  modport master (output req, output wdata, input gnt, input ack, input q, input busy);
  modport slave  (input req, input wdata, output gnt, output ack, output q, output busy);

endinterface

// File: rtl/reg2_store.sv
// Shared DW-bit storage: one enabled flop per bit, async active-high clear.
// Loads d at the rising edge when en is high; no handshake of its own.
module reg2_store #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  for (genvar b = 0; b < DW; b++) begin : g_bit
    logic bit_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bit_q <= 1'b0;
      end else if (en) begin
        bit_q <= d[b];
      end
    end

    assign q[b] = bit_q;
  end

endmodule

// File: rtl/reg2_write_arbiter.sv
// Round-robin (or fixed priority with REG2ARB_FIXED_PRIO_EN) writer arbitration for one shared register.
// IDLE->WRITE->ACK: q updates one cycle after arbitration, ack the cycle after; losers wait in req.
module reg2_write_arbiter
  import reg2_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  reg2_write_arbiter_if.slave bus
);

  localparam int WW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > REG2ARB_MAX_REQ) begin : g_bad_n_req
    $error("reg2_write_arbiter: N_REQ must be in 2..%0d", REG2ARB_MAX_REQ);
  end

  state_t         state;
  logic [WW-1:0]  win;
  logic [WW-1:0]  pick;
  logic [DW-1:0]  hold;
  logic [DW-1:0]  q_val;
  logic           arb;
  logic           st_en;
  logic [N_REQ-1:0] win_oh;
  logic [DW-1:0]  wd_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_wd
    assign wd_arr[i] = bus.wdata[i*DW +: DW];
  end

  assign arb = (state == ST_IDLE) && (|bus.req);

`ifdef REG2ARB_FIXED_PRIO_EN

  function automatic logic [WW-1:0] fp_pick(input logic [N_REQ-1:0] r);
    logic [WW-1:0] sel;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[k]) begin
        sel   = WW'(k);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = fp_pick(bus.req);

`else

  logic [WW-1:0] last;

  // Search begins just past the previous winner so every requester gets a turn.
  function automatic logic [WW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [WW-1:0] l);
    logic [WW-1:0] sel;
    logic [WW-1:0] pidx;
    logic          found;
    int            pos;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos  = (int'(l) + k) % N_REQ;
      pidx = WW'(pos);
      if (!found && r[pidx]) begin
        sel   = pidx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(bus.req, last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= WW'(N_REQ - 1);
    end else if (arb) begin
      last <= pick;
    end
  end

`endif

  // Winner and data are frozen here; later req/wdata changes cannot disturb the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      win   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb) begin
            state <= ST_WRITE;
            win   <= pick;
            hold  <= wd_arr[pick];
          end
        end
        ST_WRITE: state <= ST_ACK;
        ST_ACK:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign st_en = (state == ST_WRITE);

  reg2_store #(.DW(DW)) u_store (
    .clk   (clk),
    .reset (reset),
    .en    (st_en),
    .d     (hold),
    .q     (q_val)
  );

  assign win_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  assign bus.gnt  = (state == ST_WRITE) ? win_oh : '0;
  assign bus.ack  = (state == ST_ACK)   ? win_oh : '0;
  assign bus.busy = (state != ST_IDLE);
  assign bus.q    = q_val;

endmodule

// File: tb/tb_reg2_write_arbiter.sv
// Bench for reg2_write_arbiter: expected (winner, data) pairs queued at stimulus, checked on every ack.
module tb_reg2_write_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reg2_write_arbiter_if #(.N_REQ(3), .DW(2)) bus ();

  reg2_write_arbiter #(.N_REQ(3), .DW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] dat;
  } exp_t;

  exp_t       sb [$];
  exp_t       mon_e;
  logic [2:0] prev_gnt = 3'b000;
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input logic [1:0] dat);
    exp_t e;
    e.idx = idx;
    e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive req/wdata and wait for n acks; consecutive acks must be 3 cycles apart.
  task automatic run_seq(input string tag, input logic [2:0] r, input logic [5:0] wd,
                         input int n, input logic [2:0] forbid);
    int seen;
    int last_c;
    int c;
    seen   = 0;
    last_c = -1;
    c      = 0;
    bus.req   = r;
    bus.wdata = wd;
    while (seen < n && c < 12 * n) begin
      tick();
      c++;
      if (forbid != 3'b000) chk({tag, "_forbid_gnt"}, bus.gnt & forbid, 0);
      if (bus.ack != 3'b000) begin
        if (last_c >= 0) chk({tag, "_spacing"}, c - last_c, 3);
        last_c = c;
        seen++;
      end
    end
    chk({tag, "_acks"}, seen, n);
  endtask

  // Scoreboard: every ack must match the head of the queue and follow a matching grant.
  always @(negedge clk) begin
    if (reset) begin
      prev_gnt = 3'b000;
    end else begin
      if (bus.ack != 3'b000) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", bus.ack, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_ack", bus.ack, 32'(1) << mon_e.idx);
          chk("sb_q", bus.q, mon_e.dat);
          chk("sb_prev_gnt", prev_gnt, 32'(1) << mon_e.idx);
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = 3'b000;
    bus.wdata = 6'b000000;

    // Reset state
    tick();
    chk("rst_q", bus.q, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", bus.busy, 0);

    // Single requester
    push_exp(0, 2'b10);
    bus.req   = 3'b001;
    bus.wdata = 6'b00_00_10;
    tick();
    chk("single_gnt", bus.gnt, 3'b001);
    chk("single_busy", bus.busy, 1);
    chk("single_q_old", bus.q, 2'b00);
    tick();
    chk("single_ack", bus.ack, 3'b001);
    chk("single_q_new", bus.q, 2'b10);
    chk("single_gnt_off", bus.gnt, 0);
    bus.req = 3'b000;
    tick();
    chk("single_ack_once", bus.ack, 0);
    chk("single_idle", bus.busy, 0);
    tick();

    // Reset in the middle of a write
    bus.req   = 3'b001;
    bus.wdata = 6'b00_00_11;
    tick();
    chk("midrst_gnt", bus.gnt, 3'b001);
    bus.req = 3'b000;
    #2 reset = 1'b1;
    #1;
    chk("midrst_gnt_clr", bus.gnt, 0);
    chk("midrst_busy_clr", bus.busy, 0);
    chk("midrst_q", bus.q, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_ack", bus.ack, 0);
      chk("midrst_q_hold", bus.q, 0);
    end

`ifdef REG2ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_exp(0, 2'b01);
    run_seq("simul", 3'b111, 6'b11_10_01, 4, 3'b000);
    push_exp(0, 2'b01);
    push_exp(0, 2'b01);
    run_seq("wrap_pre", 3'b111, 6'b11_10_01, 2, 3'b000);
    push_exp(0, 2'b01);
    push_exp(0, 2'b01);
    run_seq("wrap", 3'b101, 6'b11_10_01, 2, 3'b100);
`else
    push_exp(0, 2'b01);
    push_exp(1, 2'b10);
    push_exp(2, 2'b11);
    push_exp(0, 2'b01);
    run_seq("simul", 3'b111, 6'b11_10_01, 4, 3'b000);
    push_exp(1, 2'b10);
    push_exp(2, 2'b11);
    run_seq("wrap_pre", 3'b111, 6'b11_10_01, 2, 3'b000);
    push_exp(0, 2'b01);
    push_exp(2, 2'b11);
    run_seq("wrap", 3'b101, 6'b11_10_01, 2, 3'b010);
`endif
    bus.req = 3'b000;
    tick();
    tick();

    // Data changes during WRITE must not reach q
    push_exp(1, 2'b01);
    bus.req   = 3'b010;
    bus.wdata = 6'b00_01_00;
    tick();
    chk("capture_gnt", bus.gnt, 3'b010);
    bus.wdata = 6'b00_10_00;
    tick();
    chk("capture_ack", bus.ack, 3'b010);
    chk("capture_q", bus.q, 2'b01);
    bus.req = 3'b000;
    tick();
    tick();
    chk("capture_q_stable", bus.q, 2'b01);

`ifdef REG2ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_exp(0, 2'b10);
    run_seq("fixed_prio", 3'b011, 6'b00_01_10, 4, 3'b010);
`else
    // last winner is 1, so 0 goes first and the two alternate
    push_exp(0, 2'b10);
    push_exp(1, 2'b01);
    push_exp(0, 2'b10);
    run_seq("rr_pair", 3'b011, 6'b00_01_10, 3, 3'b100);
`endif
    bus.req = 3'b000;
    for (int i = 0; i < 4; i++) tick();
    chk("end_busy", bus.busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
